adc_acq_selftrig_seq: RTL and testbench
=======================================

ADC_ACQ_SELFTRIG_SEQ -- requirements
Module: adc_acq_selftrig_seq

Interface
REQ-001 SHALL have parameter ADR_LIMIT, default 8388607: largest usable burst address in the DDR3 fill region.
REQ-002 SHALL have port clk  in  1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-004 SHALL have port acq_enable  in  1: fill enable level; a rising edge starts a fill.
REQ-005 SHALL have port acq_trig  in  1: single-cycle self-trigger pulse.
REQ-006 SHALL have port fifo_ready  in  1: the DDR3 write FIFO has room for a full waveform.
REQ-007 SHALL have port async_num_bursts  in  14: data bursts per waveform.
REQ-008 SHALL have port max_waveforms  in  23: waveform limit per fill; 0 means unlimited.
REQ-009 SHALL have outputs select_fill_hdr, select_waveform_hdr, select_dat, select_checksum, checksum_init, checksum_update, each out 1: mux controls.
REQ-010 SHALL have port num_fill_bursts  out  23: total bursts in the fill.
REQ-011 SHALL have port current_waveform_num  out  23: waveform index or count.
REQ-012 SHALL have port waveform_start_adr  out  23: burst address of the current waveform header.
REQ-013 SHALL have port wr_en  out  1: FIFO write strobe, aligned with the mux's registered output.
REQ-014 SHALL have port acq_busy  out  1, port fill_done  out  1, and port drop_cnt  out  16: fill in progress, one-cycle end-of-fill pulse, and saturating count of dropped triggers.

Function
REQ-015 SHALL implement the states IDLE, ARMED, WFM_HDR, DATA, FILL_HDR, CHECKSUM and DONE; at most one select_* SHALL be high in any cycle.
REQ-016 In IDLE, on acq_enable=1 while the previous sample was 0: SHALL pulse checksum_init for 1 cycle, set burst_cnt=1 (slot 0 is reserved for the fill header), clear wfm_cnt and drop_cnt, and go to ARMED.
REQ-017 In ARMED, in priority order: SHALL go to FILL_HDR if acq_enable=0, or if max_waveforms!=0 and wfm_cnt==max_waveforms, or if burst_cnt+async_num_bursts+2 > ADR_LIMIT (24-bit compare); otherwise on acq_trig&&fifo_ready SHALL go to WFM_HDR.
REQ-018 A trigger that is not accepted (any state other than ARMED, fifo_ready=0, or an end condition true in the same cycle) SHALL increment drop_cnt, which saturates at 16'hFFFF.
REQ-019 WFM_HDR SHALL last 1 cycle with select_waveform_hdr=1 and waveform_start_adr=burst_cnt (latched on entry), then burst_cnt+=1; it SHALL go to DATA, or straight to ARMED with wfm_cnt+=1 when async_num_bursts==0.
REQ-020 DATA SHALL last exactly async_num_bursts cycles (value latched at WFM_HDR) with select_dat=1 and checksum_update=1, with burst_cnt+=1 each cycle; on exit SHALL set wfm_cnt+=1 and go to ARMED.
REQ-021 If acq_enable falls during WFM_HDR or DATA, the waveform SHALL complete before the state machine ends the fill.
REQ-022 FILL_HDR SHALL last 1 cycle with select_fill_hdr=1, then go to CHECKSUM; CHECKSUM SHALL last 1 cycle with select_checksum=1, then go to DONE.
REQ-023 current_waveform_num SHALL equal wfm_cnt: the 0-based index during WFM_HDR and the total count during FILL_HDR.
REQ-024 num_fill_bursts SHALL equal burst_cnt+1 (including the checksum burst), and SHALL be held from FILL_HDR until the next fill start.
REQ-025 wr_en SHALL equal the OR of all select_* signals delayed by 1 clock.
REQ-026 DONE SHALL pulse fill_done for 1 cycle, then wait for acq_enable=0 before going to IDLE.
REQ-027 acq_busy SHALL be high in every state except IDLE.

Reset
REQ-028 While reset=1, the state SHALL be IDLE and every output, burst_cnt, wfm_cnt and the acq_enable edge register SHALL be 0 on the next edge, including when reset arrives mid-fill.
REQ-029 acq_enable already high when reset is released SHALL NOT start a fill until it has been seen low.

Verification
REQ-030 Stimulus: async_num_bursts=4, enable, 2 triggers, then disable -> response: headers at adr 1 and 6, 4 select_dat cycles each, current_waveform_num=2 and num_fill_bursts=12 at FILL_HDR, one checksum, one fill_done.
REQ-031 Stimulus: max_waveforms=3 with 5 spaced triggers -> response: 3 waveforms and fill end with acq_enable still high; drop_cnt=2.
REQ-032 Stimulus: a trigger during DATA, and a trigger with fifo_ready=0 -> response: neither is accepted and drop_cnt increments each time.
REQ-033 Stimulus: async_num_bursts=0 -> response: the header-only waveform gives no select_dat cycles and burst_cnt advances by 1 per trigger.
REQ-034 Stimulus: ADR_LIMIT=20 with async_num_bursts=8 -> response: the fill ends after 2 waveforms with num_fill_bursts=20.
REQ-035 Stimulus: reset asserted during DATA -> response: all outputs are 0 on the next edge, and a new fill starts only after acq_enable goes low then high.

Source files
------------

// File: rtl/adc_acq_selftrig_seq.sv
// Self-triggered ADC acquisition sequencer: orders the fill header, waveform
// headers, data bursts and checksum into the DDR3 write path of one fill.
module adc_acq_selftrig_seq #(
  parameter int unsigned ADR_LIMIT = 32'd8388607
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        acq_enable,
  input  logic        acq_trig,
  input  logic        fifo_ready,
  input  logic [13:0] async_num_bursts,
  input  logic [22:0] max_waveforms,
  output logic        select_fill_hdr,
  output logic        select_waveform_hdr,
  output logic        select_dat,
  output logic        select_checksum,
  output logic        checksum_init,
  output logic        checksum_update,
  output logic [22:0] num_fill_bursts,
  output logic [22:0] current_waveform_num,
  output logic [22:0] waveform_start_adr,
  output logic        wr_en,
  output logic        acq_busy,
  output logic        fill_done,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_WFM_HDR  = 3'd2,
    S_DATA     = 3'd3,
    S_FILL_HDR = 3'd4,
    S_CHECKSUM = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [23:0] LIMIT = 24'(ADR_LIMIT);

  state_t      state_r;
  state_t      next_state_s;
  logic        enable_d_r;
  logic        en_low_seen_r;
  logic [22:0] burst_cnt_r;
  logic [22:0] wfm_cnt_r;
  logic [13:0] data_left_r;
  logic        fill_start_s;
  logic        end_s;
  logic        accept_s;
  logic        drop_s;
  logic        wfm_done_s;
  logic [23:0] span_s;

  assign current_waveform_num = wfm_cnt_r;

  // Next-state decode, trigger acceptance and end-of-fill conditions.
  always_comb begin
    next_state_s = state_r;
    fill_start_s = 1'b0;
    accept_s     = 1'b0;
    wfm_done_s   = 1'b0;
    span_s       = {1'b0, burst_cnt_r} + {10'd0, async_num_bursts} + 24'd2;
    end_s        = (~acq_enable)
                 | ((max_waveforms != 23'd0) & (wfm_cnt_r == max_waveforms))
                 | (span_s > LIMIT);
    case (state_r)
      S_IDLE: begin
        // en_low_seen_r keeps an enable held high through reset from starting a fill
        if (acq_enable && !enable_d_r && en_low_seen_r) begin
          fill_start_s = 1'b1;
          next_state_s = S_ARMED;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_ARMED: begin
        if (end_s) begin
          next_state_s = S_FILL_HDR;
        end else if (acq_trig && fifo_ready) begin
          accept_s     = 1'b1;
          next_state_s = S_WFM_HDR;
        end else begin
          next_state_s = S_ARMED;
        end
      end
      S_WFM_HDR: begin
        if (async_num_bursts == 14'd0) begin
          wfm_done_s   = 1'b1;
          next_state_s = S_ARMED;
        end else begin
          next_state_s = S_DATA;
        end
      end
      S_DATA: begin
        if (data_left_r == 14'd1) begin
          wfm_done_s   = 1'b1;
          next_state_s = S_ARMED;
        end else begin
          next_state_s = S_DATA;
        end
      end
      S_FILL_HDR: next_state_s = S_CHECKSUM;
      S_CHECKSUM: next_state_s = S_DONE;
      S_DONE: begin
        if (!acq_enable) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_DONE;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
    drop_s = acq_trig & ~accept_s;
  end

  // State register, fill counters and registered mux controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r             <= S_IDLE;
      enable_d_r          <= 1'b0;
      en_low_seen_r       <= 1'b0;
      burst_cnt_r         <= 23'd0;
      wfm_cnt_r           <= 23'd0;
      data_left_r         <= 14'd0;
      select_fill_hdr     <= 1'b0;
      select_waveform_hdr <= 1'b0;
      select_dat          <= 1'b0;
      select_checksum     <= 1'b0;
      checksum_init       <= 1'b0;
      checksum_update     <= 1'b0;
      num_fill_bursts     <= 23'd0;
      waveform_start_adr  <= 23'd0;
      wr_en               <= 1'b0;
      acq_busy            <= 1'b0;
      fill_done           <= 1'b0;
      drop_cnt            <= 16'd0;
    end else begin
      state_r    <= next_state_s;
      enable_d_r <= acq_enable;
      if (!acq_enable) en_low_seen_r <= 1'b1;

      select_fill_hdr     <= (next_state_s == S_FILL_HDR);
      select_waveform_hdr <= (next_state_s == S_WFM_HDR);
      select_dat          <= (next_state_s == S_DATA);
      select_checksum     <= (next_state_s == S_CHECKSUM);
      checksum_update     <= (next_state_s == S_DATA);
      checksum_init       <= fill_start_s;
      acq_busy            <= (next_state_s != S_IDLE);
      fill_done           <= (next_state_s == S_DONE) && (state_r != S_DONE);
      wr_en <= select_fill_hdr | select_waveform_hdr | select_dat | select_checksum;

      if (fill_start_s) begin
        burst_cnt_r     <= 23'd1;
        wfm_cnt_r       <= 23'd0;
        drop_cnt        <= 16'd0;
        num_fill_bursts <= 23'd0;
      end else begin
        if (drop_s && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        if ((state_r == S_WFM_HDR) || (state_r == S_DATA)) burst_cnt_r <= burst_cnt_r + 23'd1;
        if (wfm_done_s) wfm_cnt_r <= wfm_cnt_r + 23'd1;
        // the extra burst accounts for the trailing checksum
        if ((next_state_s == S_FILL_HDR) && (state_r != S_FILL_HDR)) begin
          num_fill_bursts <= burst_cnt_r + 23'd1;
        end
      end

      if (accept_s) waveform_start_adr <= burst_cnt_r;
      if (state_r == S_WFM_HDR) begin
        data_left_r <= async_num_bursts;
      end else if (state_r == S_DATA) begin
        data_left_r <= data_left_r - 14'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_acq_selftrig_seq.sv
// Directed bench for adc_acq_selftrig_seq: a small fill model pushes expected
// headers and fill records to queues that a negedge monitor pops and checks.
module tb_adc_acq_selftrig_seq;
  localparam int unsigned LIM = 20;

  logic        clk = 1'b0;
  logic        reset, acq_enable, acq_trig, fifo_ready;
  logic [13:0] async_num_bursts;
  logic [22:0] max_waveforms;
  logic        select_fill_hdr, select_waveform_hdr, select_dat, select_checksum;
  logic        checksum_init, checksum_update;
  logic [22:0] num_fill_bursts, current_waveform_num, waveform_start_adr;
  logic        wr_en, acq_busy, fill_done;
  logic [15:0] drop_cnt;

  typedef struct { int adr; int idx; int nb; } hdr_t;
  typedef struct { int wfm; int nfb; } fill_t;

  hdr_t  hdr_q[$];
  fill_t fill_q[$];
  int    n_checks = 0;
  int    n_err = 0;
  int    m_burst, m_wfm, m_drop;
  int    dat_run, wr_run, cur_nb, wr_exp;
  bit    in_wfm;

  adc_acq_selftrig_seq #(.ADR_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .acq_enable(acq_enable), .acq_trig(acq_trig),
    .fifo_ready(fifo_ready), .async_num_bursts(async_num_bursts),
    .max_waveforms(max_waveforms), .select_fill_hdr(select_fill_hdr),
    .select_waveform_hdr(select_waveform_hdr), .select_dat(select_dat),
    .select_checksum(select_checksum), .checksum_init(checksum_init),
    .checksum_update(checksum_update), .num_fill_bursts(num_fill_bursts),
    .current_waveform_num(current_waveform_num),
    .waveform_start_adr(waveform_start_adr), .wr_en(wr_en),
    .acq_busy(acq_busy), .fill_done(fill_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop expectations as the DUT presents headers and fills.
  always @(negedge clk) begin
    hdr_t  h;
    fill_t f;
    if (reset) begin
      dat_run = 0;
      wr_run  = 0;
      in_wfm  = 0;
    end else begin
      chk("onehot_sel", ($countones({select_fill_hdr, select_waveform_hdr,
                                     select_dat, select_checksum}) <= 1), 32'd1);
      if (select_dat) dat_run++;
      if (wr_en) wr_run++;
      if ((select_waveform_hdr || select_fill_hdr) && in_wfm) begin
        chk("dat_cycles", dat_run, cur_nb);
        in_wfm = 0;
      end
      if (select_waveform_hdr) begin
        chk("hdr_pending", (hdr_q.size() > 0), 32'd1);
        if (hdr_q.size() > 0) begin
          h = hdr_q.pop_front();
          chk("wfm_adr", waveform_start_adr, h.adr);
          chk("wfm_idx", current_waveform_num, h.idx);
          cur_nb  = h.nb;
          dat_run = 0;
          in_wfm  = 1;
        end
      end
      if (select_fill_hdr) begin
        chk("fill_pending", (fill_q.size() > 0), 32'd1);
        if (fill_q.size() > 0) begin
          f = fill_q.pop_front();
          chk("fill_wfm", current_waveform_num, f.wfm);
          chk("fill_bursts", num_fill_bursts, f.nfb);
          wr_exp = f.nfb;
        end
      end
      if (fill_done) begin
        chk("wr_count", wr_run, wr_exp);
        wr_run = 0;
      end
    end
  end

  task automatic push_fill();
    fill_t f;
    f.wfm = m_wfm;
    f.nfb = m_burst + 1;
    fill_q.push_back(f);
  endtask

  task automatic push_hdr();
    hdr_t h;
    h.adr = m_burst;
    h.idx = m_wfm;
    h.nb  = int'(async_num_bursts);
    hdr_q.push_back(h);
    m_burst += 1 + int'(async_num_bursts);
    m_wfm++;
  endtask

  task automatic start_fill();
    @(posedge clk); #1 acq_enable = 1'b1;
    m_burst = 1; m_wfm = 0; m_drop = 0;
    @(posedge clk); @(negedge clk);
    chk("cks_init", checksum_init, 1);
    chk("busy_start", acq_busy, 1);
    chk("drop_clr", drop_cnt, 0);
    @(negedge clk);
    chk("cks_init_pulse", checksum_init, 0);
  endtask

  task automatic send_trig(input bit ends);
    push_hdr();
    if (ends) push_fill();
    @(posedge clk); #1 acq_trig = 1'b1;
    @(posedge clk); #1 acq_trig = 1'b0;
    repeat (int'(async_num_bursts) + 2) @(posedge clk);
  endtask

  task automatic send_trig_data_drop();
    push_hdr();
    @(posedge clk); #1 acq_trig = 1'b1;
    @(posedge clk); #1 acq_trig = 1'b0;
    @(posedge clk); #1 acq_trig = 1'b1;
    m_drop++;
    @(posedge clk); #1 acq_trig = 1'b0;
    @(negedge clk); chk("drop_in_data", drop_cnt, m_drop);
    repeat (int'(async_num_bursts) + 2) @(posedge clk);
  endtask

  task automatic drop_pulse(input string tag);
    @(posedge clk); #1 acq_trig = 1'b1;
    m_drop++;
    @(posedge clk); #1 acq_trig = 1'b0;
    @(negedge clk); chk(tag, drop_cnt, m_drop);
  endtask

  task automatic end_fill();
    push_fill();
    @(posedge clk); #1 acq_enable = 1'b0;
  endtask

  task automatic wait_fill_end(input bit busy_exp);
    int done_n = 0;
    repeat (12) begin
      @(negedge clk);
      if (fill_done) done_n++;
    end
    chk("fill_done_once", done_n, 1);
    chk("busy_after", acq_busy, busy_exp);
  endtask

  initial begin
    reset = 1'b1; acq_enable = 1'b0; acq_trig = 1'b0; fifo_ready = 1'b1;
    async_num_bursts = 14'd4; max_waveforms = 23'd0;
    m_burst = 0; m_wfm = 0; m_drop = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {select_fill_hdr, select_waveform_hdr, select_dat, select_checksum,
                     checksum_init, checksum_update, wr_en, acq_busy, fill_done}, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_nfb", num_fill_bursts, 0);
    chk("rst_wfm", current_waveform_num, 0);
    chk("rst_adr", waveform_start_adr, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // Two waveforms of 4 bursts plus a trigger during DATA and one with no FIFO room
    start_fill();
    send_trig(1'b0);
    send_trig_data_drop();
    fifo_ready = 1'b0;
    drop_pulse("drop_fifo");
    fifo_ready = 1'b1;
    end_fill();
    wait_fill_end(1'b0);
    chk("fill1_nfb_hold", num_fill_bursts, 12);
    chk("fill1_drops", drop_cnt, 2);

    // Waveform limit ends the fill with enable still high; later triggers drop
    async_num_bursts = 14'd2; max_waveforms = 23'd3;
    start_fill();
    send_trig(1'b0);
    send_trig(1'b0);
    send_trig(1'b1);
    wait_fill_end(1'b1);
    drop_pulse("drop_done_a");
    drop_pulse("drop_done_b");
    chk("max_drops", drop_cnt, 2);
    chk("max_wfm", current_waveform_num, 3);
    @(posedge clk); #1 acq_enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("idle_after_max", acq_busy, 0);

    // Header-only waveforms
    async_num_bursts = 14'd0; max_waveforms = 23'd0;
    start_fill();
    send_trig(1'b0);
    send_trig(1'b0);
    send_trig(1'b0);
    end_fill();
    wait_fill_end(1'b0);
    chk("nb0_nfb", num_fill_bursts, 5);

    // Address limit of 20 with 8-burst waveforms
    async_num_bursts = 14'd8;
    start_fill();
    send_trig(1'b0);
    send_trig(1'b1);
    wait_fill_end(1'b1);
    chk("lim_nfb", num_fill_bursts, 20);
    chk("lim_wfm", current_waveform_num, 2);
    @(posedge clk); #1 acq_enable = 1'b0;
    @(posedge clk);

    // Reset in the middle of DATA with enable held high
    async_num_bursts = 14'd4;
    start_fill();
    push_hdr();
    @(posedge clk); #1 acq_trig = 1'b1;
    @(posedge clk); #1 acq_trig = 1'b0;
    @(posedge clk);
    @(negedge clk); chk("in_data", select_dat, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ctrl", {select_fill_hdr, select_waveform_hdr, select_dat, select_checksum,
                         checksum_init, checksum_update, wr_en, acq_busy, fill_done}, 0);
    chk("mid_rst_wfm", current_waveform_num, 0);
    chk("mid_rst_adr", waveform_start_adr, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); chk("no_restart", acq_busy, 0);
    @(posedge clk); #1 acq_enable = 1'b0;
    @(posedge clk);
    start_fill();
    send_trig(1'b0);
    end_fill();
    wait_fill_end(1'b0);
    chk("post_rst_nfb", num_fill_bursts, 7);

    chk("hdr_q_empty", hdr_q.size(), 0);
    chk("fill_q_empty", fill_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
